bus_timer: RTL and testbench

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_map_pkg.sv | 27 ++
 rtl/timer_prescaler.sv | 28 ++
 rtl/bus_timer.sv | 146 ++++++++++++++
 tb/tb_bus_timer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_map_pkg.sv
// Shared processor bus map: region nibbles, timer register offsets,
// CTRL/STATUS bit positions and the timer FSM encoding.
package bus_map_pkg;

    localparam logic [3:0] REGION_IMEM  = 4'h0;
    localparam logic [3:0] REGION_LED   = 4'h1;
    localparam logic [3:0] REGION_SEG7  = 4'h2;
    localparam logic [3:0] REGION_SW    = 4'h3;
    localparam logic [3:0] REGION_TIMER = 4'h4;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_IE    = 2;
    localparam int CTRL_W     = 3;
    localparam int STATUS_EXP = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Divides Clock by PRESCALE while run is high; the counter sits at 0 when idle,
// so the first tick after a start always lands PRESCALE cycles later.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic run,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] r_cnt;

    assign tick = run && (r_cnt == LAST);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_cnt <= '0;
        end else if (!run || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer: CTRL/LOAD/COUNT/STATUS registers,
// one-shot or auto-reload expiry, sticky EXP flag and a level interrupt.
module bus_timer
    import bus_map_pkg::*;
#(
    parameter logic [3:0]  BASE     = REGION_TIMER,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] rdata,
    output logic        irq
);

    timer_state_t r_state, w_state_nxt;

    logic [CTRL_W-1:0] r_ctrl;
    logic [15:0]       r_load;
    logic [15:0]       r_count;
    logic              r_exp;

    logic        w_cs, w_wr;
    logic        w_wr_ctrl, w_wr_load, w_wr_count, w_wr_status;
    logic        w_run, w_tick, w_expire, w_oneshot_end;
    logic [1:0]  w_reg;
    logic [15:0] w_rd_val;
    logic        w_unused_addr;

    assign w_cs          = (ADDR[15:12] == BASE);
    assign w_wr          = w_cs && W;
    assign w_reg         = ADDR[1:0];
    assign w_unused_addr = ^ADDR[11:2];

    assign w_wr_ctrl   = w_wr && (w_reg == REG_CTRL);
    assign w_wr_load   = w_wr && (w_reg == REG_LOAD);
    assign w_wr_count  = w_wr && (w_reg == REG_COUNT);
    assign w_wr_status = w_wr && (w_reg == REG_STATUS);

    assign w_run = (r_state == ST_RUN);

    timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .Clock (Clock),
        .Resetn(Resetn),
        .run   (w_run),
        .tick  (w_tick)
    );

    assign w_expire      = w_tick && (r_count == 16'd0);
    assign w_oneshot_end = w_expire && !r_ctrl[CTRL_AUTO];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A CTRL write in the expiry cycle decides the next state outright.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_ctrl && DOUT[CTRL_EN]) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_wr_ctrl) begin
                    if (!DOUT[CTRL_EN]) w_state_nxt = ST_IDLE;
                end else if (w_oneshot_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_ctrl <= '0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= DOUT[CTRL_W-1:0];
        end else if (w_oneshot_end) begin
            r_ctrl[CTRL_EN] <= 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_load <= '0;
        end else if (w_wr_load) begin
            r_load <= DOUT;
        end
    end

    // The tick only fires in RUN, so COUNT is frozen while idle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= DOUT;
        end else if (w_tick) begin
            if (r_count != 16'd0) begin
                r_count <= r_count - 16'd1;
            end else if (r_ctrl[CTRL_AUTO]) begin
                r_count <= r_load;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_exp <= 1'b0;
        end else if (w_expire) begin
            r_exp <= 1'b1;
        end else if (w_wr_status && DOUT[STATUS_EXP]) begin
            r_exp <= 1'b0;
        end
    end

    always_comb begin
        w_rd_val = 16'h0000;
        case (w_reg)
            REG_CTRL:   w_rd_val = {13'h0000, r_ctrl};
            REG_LOAD:   w_rd_val = r_load;
            REG_COUNT:  w_rd_val = r_count;
            REG_STATUS: w_rd_val = {15'h0000, r_exp};
            default:    w_rd_val = 16'h0000;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rdata <= 16'h0000;
        end else begin
            rdata <= w_cs ? w_rd_val : 16'h0000;
        end
    end

    assign irq = r_exp && r_ctrl[CTRL_IE];

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: two instances (PRESCALE 1 and 4) on one bus, a
// per-cycle reference model, plus hand-computed checkpoints.
module tb_bus_timer;

    logic        Clock;
    logic        Resetn;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] rdata1, rdata4;
    logic        irq1, irq4;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    bus_timer #(.BASE(4'h4), .PRESCALE(1)) dut1 (
        .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W),
        .rdata(rdata1), .irq(irq1)
    );

    bus_timer #(.BASE(4'h4), .PRESCALE(4)) dut4 (
        .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W),
        .rdata(rdata4), .irq(irq4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: the timer runs exactly while EN is set; ticks fall
    // on every PRESCALE-th cycle counted from the start of the run.
    typedef struct packed {
        logic [2:0]  ctrl;
        logic [15:0] load;
        logic [15:0] count;
        logic        exp;
        logic [15:0] rdata;
        logic [31:0] age;
    } mdl_t;

    mdl_t m[2];
    mdl_t nx[2];

    function automatic mdl_t step(mdl_t s, int p, logic [15:0] a, logic [15:0] d, logic w);
        mdl_t        n = s;
        logic        hit = (a[15:12] == 4'h4);
        logic        wr = hit && w;
        logic [1:0]  r = a[1:0];
        logic        running = s.ctrl[0];
        logic        tick = running && ((int'(s.age) % p) == p - 1);
        logic        expire = tick && (s.count == 16'd0);
        logic [15:0] v;
        if (tick) n.count = (s.count == 16'd0) ? (s.ctrl[1] ? s.load : 16'd0) : s.count - 16'd1;
        if (wr && r == 2'd2) n.count = d;
        if (wr && r == 2'd1) n.load = d;
        if (wr && r == 2'd3 && d[0]) n.exp = 1'b0;
        if (expire) n.exp = 1'b1;
        if (expire && !s.ctrl[1]) n.ctrl[0] = 1'b0;
        if (wr && r == 2'd0) n.ctrl = d[2:0];
        n.age = (running && n.ctrl[0]) ? s.age + 32'd1 : 32'd0;
        case (r)
            2'd0:    v = {13'h0, s.ctrl};
            2'd1:    v = s.load;
            2'd2:    v = s.count;
            default: v = {15'h0, s.exp};
        endcase
        n.rdata = hit ? v : 16'h0000;
        return n;
    endfunction

    always_comb begin
        nx[0] = step(m[0], 1, ADDR, DOUT, W);
        nx[1] = step(m[1], 4, ADDR, DOUT, W);
    end

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m[0] <= '0;
            m[1] <= '0;
        end else begin
            m[0] <= nx[0];
            m[1] <= nx[1];
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            check("mdl_rdata_p1", rdata1, m[0].rdata);
            check("mdl_irq_p1", {15'h0, irq1}, {15'h0, m[0].exp & m[0].ctrl[2]});
            check("mdl_rdata_p4", rdata4, m[1].rdata);
            check("mdl_irq_p4", {15'h0, irq4}, {15'h0, m[1].exp & m[1].ctrl[2]});
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // Called at edge+1; the write lands on the next rising edge.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a; DOUT = d; W = 1'b1;
        cyc();
        W = 1'b0; ADDR = 16'h4002;
    endtask

    initial begin
        Resetn = 1'b0; W = 1'b0; ADDR = 16'h0000; DOUT = 16'h0000;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_rdata_p1", rdata1, 16'h0000);
        check("rst_rdata_p4", rdata4, 16'h0000);
        check("rst_irq_p1", {15'h0, irq1}, 16'h0000);
        chk_en = 1;
        @(negedge Clock) Resetn = 1'b1;
        cyc();

        ADDR = 16'h4000; cyc(); check("rst_ctrl", rdata1, 16'h0000);
        ADDR = 16'h4002; cyc(); check("rst_count", rdata1, 16'h0000);
        ADDR = 16'h4003; cyc(); check("rst_status", rdata1, 16'h0000);

        // Auto-reload, period LOAD+1 = 4 ticks.
        wr(16'h4001, 16'd3);
        wr(16'h4002, 16'd3);
        wr(16'h4000, 16'h0007);
        cyc(); check("ar_e1", rdata1, 16'd3);
        cyc(); check("ar_e2", rdata1, 16'd2);
        cyc(); check("ar_e3", rdata1, 16'd1);
        check("ar_irq_e3", {15'h0, irq1}, 16'h0000);
        cyc(); check("ar_e4", rdata1, 16'd0);
        check("ar_irq_e4", {15'h0, irq1}, 16'h0001);
        cyc(); check("ar_reload", rdata1, 16'd3);

        // STATUS clear collides with the expiry at E8.
        cyc(); cyc();
        ADDR = 16'h4003; DOUT = 16'h0001; W = 1'b1;
        cyc();
        W = 1'b0;
        cyc(); check("coll_exp", rdata1, 16'h0001);
        W = 1'b1;
        cyc();
        W = 1'b0;
        check("clr_irq", {15'h0, irq1}, 16'h0000);
        cyc(); check("clr_exp", rdata1, 16'h0000);
        wr(16'h4000, 16'h0000);
        wr(16'h4003, 16'h0001);

        // One-shot from COUNT=2.
        wr(16'h4002, 16'd2);
        wr(16'h4000, 16'h0001);
        cyc(); cyc();
        ADDR = 16'h4003;
        cyc(); cyc(); check("os_exp", rdata1, 16'h0001);
        check("os_irq", {15'h0, irq1}, 16'h0000);
        ADDR = 16'h4000; cyc(); check("os_ctrl", rdata1, 16'h0000);
        ADDR = 16'h4002; repeat (5) cyc(); check("os_count", rdata1, 16'h0000);

        // Decode: other regions read 0 and ignore writes; ADDR[11:2] ignored.
        ADDR = 16'h3002; cyc(); check("dec_miss", rdata1, 16'h0000);
        ADDR = 16'h1000; DOUT = 16'hFFFF; W = 1'b1; cyc();
        ADDR = 16'h1002; cyc();
        W = 1'b0;
        ADDR = 16'h4FF5; cyc(); check("dec_load", rdata1, 16'd3);
        ADDR = 16'h4000; cyc(); check("dec_ctrl", rdata1, 16'h0000);
        ADDR = 16'h4ABE; cyc(); check("dec_count", rdata1, 16'h0000);
        wr(16'h4000, 16'h0000);
        wr(16'h4003, 16'h0001);

        // LOAD=0 with AUTO expires every tick; a LOAD write mid-run waits for reload.
        wr(16'h4001, 16'd0);
        wr(16'h4002, 16'd0);
        wr(16'h4000, 16'h0007);
        repeat (3) cyc();
        wr(16'h4003, 16'h0001);
        ADDR = 16'h4003; cyc(); check("l0_exp", rdata1, 16'h0001);
        wr(16'h4001, 16'd2);
        repeat (8) cyc();
        wr(16'h4000, 16'h0000);
        wr(16'h4003, 16'h0001);

        // PRESCALE=4 instance: COUNT=5, reset mid-count.
        wr(16'h4002, 16'd5);
        wr(16'h4000, 16'h0001);
        repeat (10) cyc();
        check("ps_count", rdata4, 16'd3);
        Resetn = 1'b0;
        #1;
        check("mid_rst_rdata_p1", rdata1, 16'h0000);
        check("mid_rst_rdata_p4", rdata4, 16'h0000);
        check("mid_rst_irq_p4", {15'h0, irq4}, 16'h0000);
        repeat (2) @(posedge Clock);
        @(negedge Clock) Resetn = 1'b1;
        ADDR = 16'h4002;
        repeat (20) cyc();
        check("ps_hold", rdata4, 16'h0000);
        ADDR = 16'h4000; cyc(); check("ps_ctrl", rdata4, 16'h0000);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
